// File: rtl/data_memory_access_controller_pkg.sv
// Shared encodings for the MEM-stage data-memory access controller:
// funct3 load/store codes, FSM state constants and opcode values.
package data_memory_access_controller_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Fields of the in-flight access needed to shape the returning load word.
    typedef struct packed {
        logic       is_load;
        logic [2:0] funct3;
        logic [1:0] lane;
    } access_info_t;

endpackage

// File: rtl/data_memory_access_controller_if.sv
// Data-memory request/ready bus; master is the controller, slave the memory.
interface data_memory_access_controller_if #(
    parameter int XLEN = 32
);
    logic            dmem_req;
    logic            dmem_write;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_write_data;
    logic [3:0]      dmem_write_strobe;
    logic            dmem_ready;
    logic [XLEN-1:0] dmem_read_data;

    modport master (
        output dmem_req, dmem_write, dmem_addr, dmem_write_data, dmem_write_strobe,
        input  dmem_ready, dmem_read_data
    );

    modport slave (
        input  dmem_req, dmem_write, dmem_addr, dmem_write_data, dmem_write_strobe,
        output dmem_ready, dmem_read_data
    );
endinterface

// File: rtl/data_memory_access_controller_load_store_aligner.sv
// Combinational byte-lane logic: store strobes and replicated data,
// misalignment detection, and extension of the returned load word.
module load_store_aligner
    import data_memory_access_controller_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            is_store,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] store_src,
    output logic [3:0]      write_strobe,
    output logic [XLEN-1:0] write_data,
    output logic            misaligned,
    input  logic [2:0]      load_funct3,
    input  logic [1:0]      load_addr_lo,
    input  logic [XLEN-1:0] read_word,
    output logic [XLEN-1:0] load_result
);

    logic is_word;
    logic is_half;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // LW and SW share one encoding; LHU exists only on the load side.
    assign is_word    = (funct3 == F3_LW);
    assign is_half    = (funct3 == F3_LH) | (~is_store & (funct3 == F3_LHU));
    assign misaligned = (is_word & (addr_lo != 2'b00)) | (is_half & addr_lo[0]);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        write_strobe = 4'b0000;
        write_data   = store_src;
        case (funct3)
            F3_SB: begin
                write_strobe = 4'b0001 << addr_lo;
                write_data   = {(XLEN/8){store_src[7:0]}};
            end
            F3_SH: begin
                write_strobe = 4'b0011 << addr_lo;
                write_data   = {(XLEN/16){store_src[15:0]}};
            end
            F3_SW:   write_strobe = 4'b1111;
            default: ;
        endcase
    end

    assign sel_byte = read_word[8*load_addr_lo +: 8];
    assign sel_half = read_word[16*load_addr_lo[1] +: 16];

    always_comb begin
        load_result = '0;
        case (load_funct3)
            F3_LB:   load_result = {{(XLEN-8){sel_byte[7]}}, sel_byte};
            F3_LH:   load_result = {{(XLEN-16){sel_half[15]}}, sel_half};
            F3_LW:   load_result = read_word;
            F3_LBU:  load_result = {{(XLEN-8){1'b0}}, sel_byte};
            F3_LHU:  load_result = {{(XLEN-16){1'b0}}, sel_half};
            default: load_result = '0;
        endcase
    end

endmodule

// File: rtl/data_memory_access_controller.sv
// MEM-stage sequencer: issues one data-memory access per EX/MEM instruction,
// stalls the pipeline until ready or timeout, and returns the extended load.
module data_memory_access_controller
    import data_memory_access_controller_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush,
    input  logic                            MEM_memory_read,
    input  logic                            MEM_memory_write,
    input  logic [2:0]                      MEM_funct3,
    input  logic [XLEN-1:0]                 MEM_alu_result,
    input  logic [XLEN-1:0]                 MEM_read_data2,
    data_memory_access_controller_if.master bus,
    output logic                            pipeline_stall,
    output logic [XLEN-1:0]                 load_data,
    output logic                            load_valid,
    output logic                            misaligned_load,
    output logic                            misaligned_store,
    output logic                            access_fault
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] COUNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [1:0]      state;
    logic [CW-1:0]   timeout_count;
    logic            discard;
    access_info_t    info_q;

    logic            access;
    logic            in_idle;
    logic            in_busy;
    logic            misaligned;
    logic            launch;
    logic [3:0]      store_strobe;
    logic [XLEN-1:0] store_data;
    logic [XLEN-1:0] load_ext;

    load_store_aligner #(.XLEN(XLEN)) u_aligner (
        .is_store     (MEM_memory_write),
        .funct3       (MEM_funct3),
        .addr_lo      (MEM_alu_result[1:0]),
        .store_src    (MEM_read_data2),
        .write_strobe (store_strobe),
        .write_data   (store_data),
        .misaligned   (misaligned),
        .load_funct3  (info_q.funct3),
        .load_addr_lo (info_q.lane),
        .read_word    (bus.dmem_read_data),
        .load_result  (load_ext)
    );

    assign access   = MEM_memory_read | MEM_memory_write;
    assign in_idle  = (state == ST_IDLE);
    assign in_busy  = (state == ST_BUSY);
    assign launch   = in_idle & access & ~misaligned & ~flush;

    assign pipeline_stall   = launch | in_busy;
    // A simultaneous read+write is a store, so only the store flag may fire.
    assign misaligned_load  = in_idle & MEM_memory_read & ~MEM_memory_write & misaligned;
    assign misaligned_store = in_idle & MEM_memory_write & misaligned;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                 <= ST_IDLE;
            timeout_count         <= '0;
            discard               <= 1'b0;
            info_q                <= '0;
            bus.dmem_req          <= 1'b0;
            bus.dmem_write        <= 1'b0;
            bus.dmem_addr         <= '0;
            bus.dmem_write_data   <= '0;
            bus.dmem_write_strobe <= 4'b0000;
            load_data             <= '0;
            load_valid            <= 1'b0;
            access_fault          <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            load_valid   <= 1'b0;
            access_fault <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        bus.dmem_req          <= 1'b1;
                        bus.dmem_write        <= MEM_memory_write;
                        bus.dmem_addr         <= {MEM_alu_result[XLEN-1:2], 2'b00};
                        bus.dmem_write_data   <= store_data;
                        bus.dmem_write_strobe <= store_strobe;
                        info_q.is_load        <= ~MEM_memory_write;
                        info_q.funct3         <= MEM_funct3;
                        info_q.lane           <= MEM_alu_result[1:0];
                        timeout_count         <= '0;
                        discard               <= 1'b0;
                        state                 <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    timeout_count <= timeout_count + 1'b1;
                    if (flush) discard <= 1'b1;
                    // Ready wins over a timeout landing in the same cycle.
                    if (bus.dmem_ready) begin
                        load_data    <= load_ext;
                        load_valid   <= info_q.is_load & ~discard & ~flush;
                        bus.dmem_req <= 1'b0;
                        state        <= ST_DONE;
                    end else if (timeout_count == COUNT_LAST) begin
                        bus.dmem_req <= 1'b0;
                        access_fault <= 1'b1;
                        state        <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    discard <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    bus.dmem_req <= 1'b0;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/data_memory_access_controller.md
Name: data_memory_access_controller

Overview:
- Sequences every data-memory access held in the EX/MEM pipeline register against a data memory with a req/ready handshake.
- Stalls the pipeline (IF/ID, ID/EX, EX/MEM hold; MEM/WB bubble) until the access completes.
- Generates byte strobes and lane-replicated store data, and sign- or zero-extends load data.
- Flags misaligned accesses and bus timeouts to the trap controller.
- Sits in the MEM stage, between the EX/MEM register outputs and the data memory.

Parameters:
XLEN, 32, datapath width
TIMEOUT_CYCLES, 16, maximum cycles in BUSY before the access is aborted with a fault

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
flush  in  1  trap/branch flush of the MEM-stage instruction
MEM_memory_read  in  1  load in MEM stage
MEM_memory_write  in  1  store in MEM stage
MEM_funct3  in  3  access size and sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
MEM_alu_result  in  XLEN  effective address
MEM_read_data2  in  XLEN  store source data
dmem_req  out  1  request to memory
dmem_write  out  1  1 = store, 0 = load
dmem_addr  out  XLEN  word-aligned address ({addr[XLEN-1:2], 2'b00})
dmem_write_data  out  XLEN  lane-replicated store data
dmem_write_strobe  out  4  byte enables
dmem_ready  in  1  memory completion (load data valid this cycle)
dmem_read_data  in  XLEN  raw read word
pipeline_stall  out  1  hold IF/ID, ID/EX, EX/MEM; insert bubble into MEM/WB
load_data  out  XLEN  extended load result for write-back
load_valid  out  1  load_data is valid for the MEM-stage instruction this cycle
misaligned_load  out  1  misaligned load detected
misaligned_store  out  1  misaligned store detected
access_fault  out  1  timeout fault, one-cycle pulse

Behaviour:
- States: IDLE, BUSY, DONE. On reset: IDLE; dmem_req, dmem_write, load_valid, access_fault = 0; dmem_addr, dmem_write_data, dmem_write_strobe, load_data = 0; timeout counter = 0.
- access = MEM_memory_read | MEM_memory_write.
- Misalignment:
  - Misaligned when a word access has addr[1:0] != 0, or a halfword access has addr[0] != 0.
  - misaligned_load and misaligned_store are combinational and valid only in IDLE.
  - A misaligned access issues no request and raises no stall.
- pipeline_stall is combinational: (IDLE & access & ~misaligned & ~flush) | BUSY.
- IDLE:
  - If access & ~misaligned & ~flush, at the next edge: latch dmem_addr, dmem_write, dmem_write_data, dmem_write_strobe; set dmem_req = 1; go to BUSY; clear the counter.
  - Otherwise stay in IDLE.
- BUSY:
  - dmem_req and all latched request fields are held stable.
  - Counter increments every cycle.
  - dmem_ready = 1: capture the extended load into load_data, drop dmem_req, go to DONE.
  - Counter == TIMEOUT_CYCLES-1 with no ready: drop dmem_req, pulse access_fault for one cycle, go to DONE.
  - flush in BUSY cannot cancel the in-flight access. It sets a discard flag.
- DONE:
  - pipeline_stall = 0; the MEM instruction advances this cycle and is not re-issued.
  - load_valid = 1 only for a completed load when neither the discard flag nor a fault is set.
  - Next edge: go to IDLE and clear the discard flag.
- Best-case load latency: 3 cycles in MEM with ready returned in the first BUSY cycle (IDLE stall, BUSY, DONE).
- Store strobes:
  - SB: 4'b0001 << addr[1:0]; data = {4{rs2[7:0]}}.
  - SH: 4'b0011 << addr[1:0]; data = {2{rs2[15:0]}}.
  - SW: 4'b1111; data = rs2.
- Load data:
  - Select byte/half by addr[1:0] from dmem_read_data.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Any other funct3 returns 0.
- Simultaneous events:
  - Read and write both asserted is treated as a store.
  - ready arriving on the same cycle as a timeout counts as success.
- Reset mid-access aborts immediately to IDLE with req = 0. The memory is reset by the same reset.

Decomposition:
- Shared package holds: funct3 load/store encodings, state encoding (IDLE/BUSY/DONE), opcode constants.
- One sub-module, load_store_aligner, is combinational: produces strobes, replicated store data, misalignment flags and load extension.
- The FSM, timeout counter and request registers live in the top module.

Test Plan:
- LW at 0x1000_0040, ready after 2 BUSY cycles, read data 0xDEADBEEF -> stall high for 3 cycles, load_data = 0xDEADBEEF with load_valid for 1 cycle, dmem_addr = 0x1000_0040.
- SB at 0x2000_0003, rs2 = 0x0000_00A5, ready immediately -> strobe 4'b1000, write data 0xA5A5A5A5, dmem_write = 1, load_valid = 0.
- LB at 0x0000_0002, read word 0x0080_0000 -> load_data = 0xFFFF_FF80; LBU at the same address -> 0x0000_0080.
- LH at 0x0000_0001 -> misaligned_load = 1, dmem_req never rises, stall = 0.
- Load with ready never asserted -> after 16 BUSY cycles access_fault pulses once, dmem_req drops, load_valid = 0.
- Flush during BUSY of an LW -> request completes, load_valid = 0 in DONE. Reset low mid-BUSY -> dmem_req = 0 immediately and state is IDLE.
